// File: rtl/div_seq_pkg.sv
// Shared constants and helpers for the RV32M iterative divider: op encodings,
// one-hot controller states and small sign/magnitude helpers.
package div_seq_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 6;

  // Same encoding as funct3[1:0] of the M-extension divide ops.
  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  typedef enum logic [4:0] {
    DIVST_IDLE = 5'b00001,
    DIVST_PREP = 5'b00010,
    DIVST_ITER = 5'b00100,
    DIVST_FIX  = 5'b01000,
    DIVST_DONE = 5'b10000
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIVOP_DIV) || (op == DIVOP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIVOP_REM) || (op == DIVOP_REMU);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response handshake bundle between the execute stage (master) and
// the divide controller (slave).
interface div_seq_if;
  import div_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [RD_W-1:0]   req_rd;
  logic              kill;
  logic              busy;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [RD_W-1:0]   resp_rd;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, kill, resp_ready,
    input  req_ready, busy, resp_valid, resp_data, resp_rd
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, kill, resp_ready,
    output req_ready, busy, resp_valid, resp_data, resp_rd
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step on the {rem, quo} pair.
module div_step
  import div_seq_pkg::*;
(
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [2*DATA_W:0] shifted;
  logic [DATA_W+1:0] diff;

  assign shifted = {rem_in, quo_in} << 1;
  // One extra bit on the difference so its MSB is the borrow.
  assign diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};

  assign rem_out = diff[DATA_W+1] ? shifted[2*DATA_W:DATA_W] : diff[DATA_W:0];
  assign quo_out = shifted[DATA_W-1:0] | {{(DATA_W-1){1'b0}}, ~diff[DATA_W+1]};

endmodule

// File: rtl/div_seq.sv
// Iterative DIV/DIVU/REM/REMU controller with a 32-step restoring datapath.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module div_seq
  import div_seq_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  div_state_e        state_reg, state_next;
  logic [1:0]        op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [RD_W-1:0]   rd_reg;
  logic [DATA_W:0]   rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [DATA_W-1:0] resp_data_reg;

  logic              is_signed;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic              div_zero, overflow, early_out, special;
  logic              accept;
  logic [DATA_W:0]   step_rem;
  logic [DATA_W-1:0] step_quo;

  assign is_signed = op_is_signed(op_reg);
  assign abs_a     = mag(a_reg, is_signed);
  assign abs_b     = mag(b_reg, is_signed);
  assign div_zero  = (b_reg == '0);
  assign overflow  = is_signed && (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (abs_a < abs_b);
`else
  assign early_out = 1'b0;
`endif
  assign special   = div_zero || overflow || early_out;
  assign accept    = (state_reg == DIVST_IDLE) && bus.req_valid && !bus.kill;

  div_step u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (b_reg),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= DIVST_IDLE;
    else       state_reg <= state_next;
  end

  // Special cases pass through FIX with their final values preloaded and sign
  // flags cleared, so result selection lives in one place (2-edge latency).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIVST_IDLE: if (accept) state_next = DIVST_PREP;
      DIVST_PREP: state_next = special ? DIVST_FIX : DIVST_ITER;
      DIVST_ITER: if (count_reg == CNT_W'(DATA_W - 1)) state_next = DIVST_FIX;
      DIVST_FIX:  state_next = DIVST_DONE;
      DIVST_DONE: if (bus.resp_ready) state_next = DIVST_IDLE;
      default:    state_next = DIVST_IDLE;
    endcase
    if (bus.kill) state_next = DIVST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rd_reg        <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      count_reg     <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      case (state_reg)
        DIVST_IDLE: begin
          if (accept) begin
            op_reg <= bus.req_op;
            a_reg  <= bus.req_a;
            b_reg  <= bus.req_b;
            rd_reg <= bus.req_rd;
          end
        end
        DIVST_PREP: begin
          count_reg <= '0;
          if (special) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            if (div_zero) begin
              quo_reg <= '1;
              rem_reg <= {1'b0, a_reg};
            end else if (overflow) begin
              quo_reg <= 32'h8000_0000;
              rem_reg <= '0;
            end else begin
              quo_reg <= '0;
              rem_reg <= {1'b0, a_reg};
            end
          end else begin
            q_neg_reg <= is_signed && (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]);
            r_neg_reg <= is_signed && a_reg[DATA_W-1];
            quo_reg   <= abs_a;
            rem_reg   <= '0;
            b_reg     <= abs_b;
          end
        end
        DIVST_ITER: begin
          rem_reg   <= step_rem;
          quo_reg   <= step_quo;
          count_reg <= count_reg + 1'b1;
        end
        DIVST_FIX: begin
          if (op_is_rem(op_reg))
            resp_data_reg <= r_neg_reg ? (~rem_reg[DATA_W-1:0] + 1'b1) : rem_reg[DATA_W-1:0];
          else
            resp_data_reg <= q_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_reg == DIVST_IDLE);
  assign bus.busy       = (state_reg != DIVST_IDLE);
  assign bus.resp_valid = (state_reg == DIVST_DONE);
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_rd    = rd_reg;

endmodule
